// File: rtl/io_pkg.sv
// Shared state encodings and fixed output codes for the IO stream unit.
package io_pkg;

    typedef enum logic [1:0] {
        IN_IDLE,
        IN_RDY,
        IN_VAL
    } in_state_e;

    typedef enum logic [2:0] {
        OUT_IDLE,
        OUT_RDY,
        OUT_ACK,
        OUT_NEXT,
        OUT_SHIFT
    } out_state_e;

    localparam logic [3:0] SIGN_PREFIX = 4'b1111;
    localparam logic [4:0] FINISH_CODE = 5'b00110;

    function automatic logic [4:0] sign_code(input logic sign);
        return {SIGN_PREFIX, sign};
    endfunction

    // Octal drops the digit LSB; decimal carries the whole BCD nibble.
    function automatic logic [4:0] digit_code(input logic dec, input logic [3:0] digit);
        return dec ? {1'b1, digit} : {2'b10, digit[3:1]};
    endfunction

endpackage

// File: rtl/io_sync_fifo.sv
// Small show-ahead FIFO: head is visible on data_o whenever not empty.
module io_sync_fifo #(
    parameter int WIDTH = 5,
    parameter int DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       resetn,
    input  logic                       flush_i,
    input  logic                       push_i,
    input  logic [WIDTH-1:0]           data_i,
    input  logic                       pop_i,
    output logic [WIDTH-1:0]           data_o,
    output logic [$clog2(DEPTH):0]     level_o,
    output logic                       full_o,
    output logic                       empty_o
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW:0]      wr_q, wr_d;
    logic [AW:0]      rd_q, rd_d;
    logic             do_push;
    logic             do_pop;

    // Pointers carry an extra wrap bit so full and empty are distinguishable.
    assign level_o = wr_q - rd_q;
    assign full_o  = (level_o == (AW + 1)'(DEPTH));
    assign empty_o = (wr_q == rd_q);
    assign data_o  = empty_o ? '0 : mem_q[rd_q[AW-1:0]];

    assign do_push = push_i && !full_o && !flush_i;
    assign do_pop  = pop_i && !empty_o && !flush_i;

    always_comb begin
        wr_d = wr_q;
        rd_d = rd_q;
        if (flush_i) begin
            wr_d = '0;
            rd_d = '0;
        end else begin
            if (do_push) wr_d = wr_q + 1'b1;
            if (do_pop)  rd_d = rd_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            wr_q <= '0;
            rd_q <= '0;
        end else begin
            wr_q <= wr_d;
            rd_q <= rd_d;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_q[AW-1:0]] <= data_i;
    end

endmodule

// File: rtl/io_stream_unit.sv
// Paper-tape style IO channel: handshaked code input into a FIFO, and a
// sign/digit/finish code stream out to a device, one direction at a time.
module io_stream_unit
    import io_pkg::*;
#(
    parameter int                CODE_W     = 5,
    parameter int                FIFO_DEPTH = 4,
    parameter int                OCT_DIGITS = 10,
    parameter int                DEC_DIGITS = 7,
    parameter logic [CODE_W-1:0] END_CODE   = CODE_W'(5'b00111)
) (
    input  logic                          clk,
    input  logic                          resetn,
    input  logic                          start_input_i,
    input  logic                          stop_input_i,
    input  logic                          start_output_i,
    input  logic                          stop_output_i,
    input  logic                          dec_mode_i,
    output logic                          in_rdy_o,
    input  logic                          in_val_i,
    input  logic [CODE_W-1:0]             in_data_i,
    output logic                          code_valid_o,
    output logic [CODE_W-1:0]             code_data_o,
    input  logic                          code_pop_i,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_level_o,
    output logic                          overflow_o,
    output logic                          out_rdy_o,
    input  logic                          out_ack_i,
    output logic [CODE_W-1:0]             out_data_o,
    input  logic                          sign_i,
    input  logic [3:0]                    digit_i,
    output logic                          shift_req_o,
    input  logic                          shift_done_i,
    output logic                          out_finish_o,
    output logic                          input_active_o,
    output logic                          output_active_o
);

    localparam int MAX_N = (OCT_DIGITS > DEC_DIGITS) ? OCT_DIGITS : DEC_DIGITS;
    localparam int IDX_W = $clog2(MAX_N + 2);
    localparam logic [IDX_W-1:0] OCT_N = IDX_W'(OCT_DIGITS);
    localparam logic [IDX_W-1:0] DEC_N = IDX_W'(DEC_DIGITS);

    in_state_e        in_state_q, in_state_d;
    logic             end_q, end_d;
    logic             ovf_q, ovf_d;
    logic             val_prev_q;

    out_state_e       out_state_q, out_state_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic             mode_q, mode_d;
    logic [CODE_W-1:0] out_data_q, out_data_d;

    logic             fifo_push, fifo_flush, fifo_full, fifo_empty;
    logic             start_in_acc, start_out_acc;
    logic             shift_req, finish;
    logic [IDX_W-1:0] n_last, load_idx;
    logic [4:0]       load_code;

    // Input takes priority when both directions are started together.
    assign start_in_acc  = start_input_i && !stop_input_i && (out_state_q == OUT_IDLE);
    assign start_out_acc = start_output_i && !stop_output_i && (out_state_q == OUT_IDLE)
                           && (in_state_q == IN_IDLE) && !start_in_acc;

    io_sync_fifo #(
        .WIDTH (CODE_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .resetn  (resetn),
        .flush_i (fifo_flush),
        .push_i  (fifo_push),
        .data_i  (in_data_i),
        .pop_i   (code_pop_i),
        .data_o  (code_data_o),
        .level_o (fifo_level_o),
        .full_o  (fifo_full),
        .empty_o (fifo_empty)
    );

    assign code_valid_o   = !fifo_empty;
    assign overflow_o     = ovf_q;
    assign in_rdy_o       = (in_state_q == IN_RDY) && !fifo_full;
    assign input_active_o = (in_state_q != IN_IDLE);

    always_comb begin
        in_state_d = in_state_q;
        end_d      = end_q;
        ovf_d      = ovf_q;
        fifo_push  = 1'b0;
        fifo_flush = 1'b0;
        unique case (in_state_q)
            IN_RDY: begin
                if (in_val_i && !fifo_full) begin
                    fifo_push  = 1'b1;
                    end_d      = (in_data_i == END_CODE);
                    in_state_d = IN_VAL;
                end else if (in_val_i && !val_prev_q && fifo_full) begin
                    ovf_d = 1'b1;
                end
            end
            IN_VAL: begin
                if (!in_val_i) begin
                    in_state_d = end_q ? IN_IDLE : IN_RDY;
                    end_d      = 1'b0;
                end
            end
            default: ;
        endcase
        if (start_in_acc) begin
            in_state_d = IN_RDY;
            fifo_flush = 1'b1;
            ovf_d      = 1'b0;
            end_d      = 1'b0;
        end
        // A handshake completing in the stop cycle is still stored.
        if (stop_input_i) begin
            in_state_d = IN_IDLE;
            end_d      = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            in_state_q <= IN_IDLE;
            end_q      <= 1'b0;
            ovf_q      <= 1'b0;
            val_prev_q <= 1'b0;
        end else begin
            in_state_q <= in_state_d;
            end_q      <= end_d;
            ovf_q      <= ovf_d;
            val_prev_q <= in_val_i;
        end
    end

    // Code to present on the next RDY entry; NEXT still holds the old index.
    assign n_last    = mode_q ? DEC_N : OCT_N;
    assign load_idx  = (out_state_q == OUT_NEXT) ? idx_q + 1'b1 : idx_q;
    assign load_code = (load_idx <= n_last) ? digit_code(mode_q, digit_i) : FINISH_CODE;

    assign out_rdy_o       = (out_state_q == OUT_RDY);
    assign out_data_o      = out_data_q;
    assign output_active_o = (out_state_q != OUT_IDLE);
    assign shift_req_o     = shift_req;
    assign out_finish_o    = finish;

    always_comb begin
        out_state_d = out_state_q;
        idx_d       = idx_q;
        mode_d      = mode_q;
        out_data_d  = out_data_q;
        shift_req   = 1'b0;
        finish      = 1'b0;
        unique case (out_state_q)
            OUT_IDLE: begin
                if (start_out_acc) begin
                    out_state_d = OUT_RDY;
                    idx_d       = '0;
                    mode_d      = dec_mode_i;
                    out_data_d  = CODE_W'(sign_code(sign_i));
                end
            end
            OUT_RDY: begin
                if (out_ack_i) out_state_d = OUT_ACK;
            end
            OUT_ACK: begin
                if (!out_ack_i) out_state_d = OUT_NEXT;
            end
            OUT_NEXT: begin
                if (idx_q == '0) begin
                    idx_d       = load_idx;
                    out_data_d  = CODE_W'(load_code);
                    out_state_d = OUT_RDY;
                end else if (idx_q <= n_last) begin
                    shift_req = 1'b1;
                    idx_d     = load_idx;
                    if (shift_done_i) begin
                        out_data_d  = CODE_W'(load_code);
                        out_state_d = OUT_RDY;
                    end else begin
                        out_state_d = OUT_SHIFT;
                    end
                end else begin
                    finish      = 1'b1;
                    idx_d       = '0;
                    out_data_d  = '0;
                    out_state_d = OUT_IDLE;
                end
            end
            OUT_SHIFT: begin
                if (shift_done_i) begin
                    out_data_d  = CODE_W'(load_code);
                    out_state_d = OUT_RDY;
                end
            end
            default: out_state_d = OUT_IDLE;
        endcase
        if (stop_output_i) begin
            out_state_d = OUT_IDLE;
            idx_d       = '0;
            out_data_d  = '0;
            shift_req   = 1'b0;
            finish      = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            out_state_q <= OUT_IDLE;
            idx_q       <= '0;
            mode_q      <= 1'b0;
            out_data_q  <= '0;
        end else begin
            out_state_q <= out_state_d;
            idx_q       <= idx_d;
            mode_q      <= mode_d;
            out_data_q  <= out_data_d;
        end
    end

endmodule

// File: tb/tb_io_stream_unit.sv
// Randomized bench for io_stream_unit with a queue/arithmetic reference model.
module tb_io_stream_unit;

    localparam int CODE_W = 5;
    localparam int DEPTH  = 4;

    logic              clk = 1'b0;
    logic              resetn = 1'b0;
    logic              start_input_i = 0, stop_input_i = 0;
    logic              start_output_i = 0, stop_output_i = 0;
    logic              dec_mode_i = 0;
    logic              in_rdy_o;
    logic              in_val_i = 0;
    logic [CODE_W-1:0] in_data_i = '0;
    logic              code_valid_o;
    logic [CODE_W-1:0] code_data_o;
    logic              code_pop_i = 0;
    logic [2:0]        fifo_level_o;
    logic              overflow_o;
    logic              out_rdy_o;
    logic              out_ack_i = 0;
    logic [CODE_W-1:0] out_data_o;
    logic              sign_i = 0;
    logic [3:0]        digit_i = '0;
    logic              shift_req_o;
    logic              shift_done_i = 0;
    logic              out_finish_o;
    logic              input_active_o, output_active_o;

    int checks = 0;
    int errors = 0;
    logic [CODE_W-1:0] fifo_model [$];

    always #5 clk = ~clk;

    io_stream_unit #(
        .CODE_W     (CODE_W),
        .FIFO_DEPTH (DEPTH),
        .OCT_DIGITS (10),
        .DEC_DIGITS (7),
        .END_CODE   (5'b00111)
    ) dut (
        .clk             (clk),
        .resetn          (resetn),
        .start_input_i   (start_input_i),
        .stop_input_i    (stop_input_i),
        .start_output_i  (start_output_i),
        .stop_output_i   (stop_output_i),
        .dec_mode_i      (dec_mode_i),
        .in_rdy_o        (in_rdy_o),
        .in_val_i        (in_val_i),
        .in_data_i       (in_data_i),
        .code_valid_o    (code_valid_o),
        .code_data_o     (code_data_o),
        .code_pop_i      (code_pop_i),
        .fifo_level_o    (fifo_level_o),
        .overflow_o      (overflow_o),
        .out_rdy_o       (out_rdy_o),
        .out_ack_i       (out_ack_i),
        .out_data_o      (out_data_o),
        .sign_i          (sign_i),
        .digit_i         (digit_i),
        .shift_req_o     (shift_req_o),
        .shift_done_i    (shift_done_i),
        .out_finish_o    (out_finish_o),
        .input_active_o  (input_active_o),
        .output_active_o (output_active_o)
    );

    function automatic logic [20:0] snapshot();
        return {in_rdy_o, code_valid_o, code_data_o, fifo_level_o, overflow_o, out_rdy_o,
                out_data_o, shift_req_o, out_finish_o, input_active_o, output_active_o};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_start_input();
        start_input_i = 1; tick(); start_input_i = 0;
        fifo_model.delete();
    endtask

    task automatic push_code(input logic [CODE_W-1:0] code);
        int w;
        w = 0;
        while (!in_rdy_o && w < 20) begin tick(); w++; end
        checks++;
        if (!in_rdy_o) begin
            errors++; $display("FAIL push_wait: in_rdy got %0b expected 1", in_rdy_o);
        end
        in_val_i = 1; in_data_i = code; tick();
        fifo_model.push_back(code);
        in_val_i = 0; tick();
        $display("push code %05b level %0d", code, fifo_level_o);
    endtask

    // Drives one output word as the device and the digit shift register.
    task automatic run_word(input logic sgn, input logic dec, input logic same_done,
                            input bit use_fixed, input logic [3:0] fixed);
        int n, w, shifts, fins;
        logic [3:0] dig [12];
        logic [4:0] exp_code [12];
        n = dec ? 7 : 10;
        for (int i = 0; i < n; i++) dig[i] = use_fixed ? fixed : 4'($urandom_range(0, 15));
        exp_code[0] = 5'(30 + int'(sgn));
        for (int k = 1; k <= n; k++)
            exp_code[k] = dec ? 5'(16 + int'(dig[k-1])) : 5'(16 + int'(dig[k-1]) / 2);
        exp_code[n+1] = 5'd6;
        sign_i = sgn; digit_i = dig[0]; dec_mode_i = dec;
        start_output_i = 1; tick(); start_output_i = 0;
        dec_mode_i = ~dec;
        shifts = 0; fins = 0;
        for (int k = 0; k <= n + 1; k++) begin
            w = 0;
            while (!out_rdy_o && w < 20) begin tick(); w++; end
            checks++;
            if (!out_rdy_o) begin
                errors++; $display("FAIL rdy_wait idx %0d: out_rdy got 0 expected 1", k);
                return;
            end
            checks++;
            if (out_data_o !== exp_code[k]) begin
                errors++; $display("FAIL out_data idx %0d: got %05b expected %05b", k, out_data_o, exp_code[k]);
            end
            $display("word idx %0d out_data %05b", k, out_data_o);
            out_ack_i = 1; sign_i = 1'($urandom); tick();
            repeat ($urandom_range(0, 2)) tick();
            checks++;
            if (out_data_o !== exp_code[k]) begin
                errors++; $display("FAIL out_data_hold idx %0d: got %05b expected %05b", k, out_data_o, exp_code[k]);
            end
            out_ack_i = 0; tick();
            if (k == 0) begin
                checks++;
                if ({shift_req_o, out_finish_o} !== 2'b00) begin
                    errors++; $display("FAIL after_sign: req/finish got %02b expected 00", {shift_req_o, out_finish_o});
                end
            end else if (k <= n) begin
                if (shift_req_o) shifts++;
                if (out_finish_o) fins++;
                digit_i = (k < n) ? dig[k] : 4'($urandom_range(0, 15));
                if (same_done) begin
                    shift_done_i = 1; tick(); shift_done_i = 0;
                end else begin
                    tick();
                    checks++;
                    if (shift_req_o !== 1'b0) begin
                        errors++; $display("FAIL shift_req_len idx %0d: got %0b expected 0", k, shift_req_o);
                    end
                    repeat ($urandom_range(0, 2)) tick();
                    shift_done_i = 1; tick(); shift_done_i = 0;
                end
            end else begin
                if (out_finish_o) fins++;
                if (shift_req_o) shifts++;
                tick();
                checks++;
                if (output_active_o !== 1'b0) begin
                    errors++; $display("FAIL active_after_finish: got %0b expected 0", output_active_o);
                end
            end
        end
        checks++;
        if (shifts != n) begin
            errors++; $display("FAIL shift_count: got %0d expected %0d", shifts, n);
        end
        checks++;
        if (fins != 1) begin
            errors++; $display("FAIL finish_count: got %0d expected 1", fins);
        end
    endtask

    task automatic test_reset();
        resetn = 0;
        repeat (2) tick();
        checks++;
        if (snapshot() !== 21'd0) begin
            errors++; $display("FAIL reset_outputs: got %06h expected 000000", snapshot());
        end
        @(negedge clk); resetn = 1; tick();
        $display("reset released");
    endtask

    task automatic test_oct_word();
        run_word(1'b1, 1'b0, 1'b0, 1'b1, 4'hE);
    endtask

    task automatic test_dec_word();
        run_word(1'b0, 1'b1, 1'b1, 1'b1, 4'h9);
    endtask

    task automatic test_random_words();
        for (int i = 0; i < 4; i++)
            run_word(1'($urandom), 1'($urandom), 1'($urandom), 1'b0, 4'h0);
    endtask

    task automatic test_input_codes();
        logic [CODE_W-1:0] exp_head;
        pulse_start_input();
        push_code(5'b10011);
        push_code(5'b10101);
        push_code(5'b00111);
        checks++;
        if (fifo_level_o !== 3'd3) begin
            errors++; $display("FAIL codes_level: got %0d expected 3", fifo_level_o);
        end
        checks++;
        if ({input_active_o, in_rdy_o} !== 2'b00) begin
            errors++; $display("FAIL codes_end: active/rdy got %02b expected 00", {input_active_o, in_rdy_o});
        end
        while (fifo_model.size() > 0) begin
            exp_head = fifo_model.pop_front();
            checks++;
            if ({code_valid_o, code_data_o} !== {1'b1, exp_head}) begin
                errors++; $display("FAIL codes_head: got %0b/%05b expected 1/%05b", code_valid_o, code_data_o, exp_head);
            end
            code_pop_i = 1; tick(); code_pop_i = 0;
            $display("pop code %05b", exp_head);
        end
        code_pop_i = 1; tick(); code_pop_i = 0;
        checks++;
        if ({code_valid_o, fifo_level_o} !== 4'b0000) begin
            errors++; $display("FAIL pop_empty: valid/level got %04b expected 0000", {code_valid_o, fifo_level_o});
        end
    endtask

    task automatic test_random_fifo();
        int op;
        logic [CODE_W-1:0] code, head;
        pulse_start_input();
        for (int i = 0; i < 40; i++) begin
            op = $urandom_range(0, 2);
            code = 5'($urandom_range(0, 31));
            if (code == 5'b00111) code = 5'b01000;
            if (op == 0 && fifo_model.size() < DEPTH) begin
                push_code(code);
            end else if (op == 1 && fifo_model.size() > 0) begin
                code_pop_i = 1; tick(); code_pop_i = 0;
                void'(fifo_model.pop_front());
                $display("pop level %0d", fifo_level_o);
            end else if (op == 2 && fifo_model.size() > 0 && fifo_model.size() < DEPTH) begin
                in_val_i = 1; in_data_i = code; code_pop_i = 1; tick();
                in_val_i = 0; code_pop_i = 0; tick();
                void'(fifo_model.pop_front());
                fifo_model.push_back(code);
                $display("push+pop code %05b level %0d", code, fifo_level_o);
            end
            checks++;
            if (fifo_level_o !== 3'(fifo_model.size())) begin
                errors++; $display("FAIL rand_level: got %0d expected %0d", fifo_level_o, fifo_model.size());
            end
            if (fifo_model.size() > 0) begin
                head = fifo_model[0];
                checks++;
                if (code_data_o !== head) begin
                    errors++; $display("FAIL rand_head: got %05b expected %05b", code_data_o, head);
                end
            end
        end
        stop_input_i = 1; tick(); stop_input_i = 0;
    endtask

    task automatic test_overflow();
        pulse_start_input();
        checks++;
        if ({fifo_level_o, input_active_o} !== 4'b0001) begin
            errors++; $display("FAIL flush_on_start: level/active got %04b expected 0001", {fifo_level_o, input_active_o});
        end
        for (int i = 0; i < DEPTH; i++) push_code(5'(16 + i));
        checks++;
        if ({in_rdy_o, fifo_level_o} !== 4'b0100) begin
            errors++; $display("FAIL full_rdy: rdy/level got %04b expected 0100", {in_rdy_o, fifo_level_o});
        end
        in_val_i = 1; in_data_i = 5'b11011; tick(); in_val_i = 0; tick();
        checks++;
        if ({overflow_o, fifo_level_o, input_active_o} !== 5'b11001) begin
            errors++; $display("FAIL overflow: ovf/level/active got %05b expected 11001", {overflow_o, fifo_level_o, input_active_o});
        end
        code_pop_i = 1; tick(); code_pop_i = 0;
        checks++;
        if ({in_rdy_o, code_data_o} !== {1'b1, 5'd17}) begin
            errors++; $display("FAIL after_pop: rdy/head got %0b/%05b expected 1/10001", in_rdy_o, code_data_o);
        end
        pulse_start_input();
        checks++;
        if ({overflow_o, fifo_level_o} !== 4'b0000) begin
            errors++; $display("FAIL restart_flush: ovf/level got %04b expected 0000", {overflow_o, fifo_level_o});
        end
        stop_input_i = 1; tick(); stop_input_i = 0;
        checks++;
        if ({in_rdy_o, input_active_o} !== 2'b00) begin
            errors++; $display("FAIL stop_input: rdy/active got %02b expected 00", {in_rdy_o, input_active_o});
        end
    endtask

    task automatic test_exclusion_stop();
        int w;
        start_input_i = 1; stop_input_i = 1; tick(); start_input_i = 0; stop_input_i = 0;
        checks++;
        if (input_active_o !== 1'b0) begin
            errors++; $display("FAIL stop_beats_start: active got %0b expected 0", input_active_o);
        end
        pulse_start_input();
        start_output_i = 1; tick(); start_output_i = 0;
        checks++;
        if ({output_active_o, out_rdy_o, input_active_o} !== 3'b001) begin
            errors++; $display("FAIL start_out_ignored: got %03b expected 001", {output_active_o, out_rdy_o, input_active_o});
        end
        in_val_i = 1; in_data_i = 5'b10001; tick();
        stop_input_i = 1; tick(); stop_input_i = 0; in_val_i = 0;
        checks++;
        if ({in_rdy_o, input_active_o} !== 2'b00) begin
            errors++; $display("FAIL stop_mid_handshake: rdy/active got %02b expected 00", {in_rdy_o, input_active_o});
        end
        sign_i = 1; start_output_i = 1; tick(); start_output_i = 0;
        w = 0;
        while (!out_rdy_o && w < 20) begin tick(); w++; end
        out_ack_i = 1; tick();
        stop_output_i = 1;
        checks++;
        if (out_finish_o !== 1'b0) begin
            errors++; $display("FAIL stop_finish: got %0b expected 0", out_finish_o);
        end
        tick(); stop_output_i = 0; out_ack_i = 0;
        checks++;
        if ({out_rdy_o, output_active_o, out_finish_o} !== 3'b000) begin
            errors++; $display("FAIL stop_output: rdy/active/finish got %03b expected 000", {out_rdy_o, output_active_o, out_finish_o});
        end
        $display("stop during ack done");
    endtask

    task automatic test_reset_mid_shift();
        int w;
        sign_i = 0; digit_i = 4'h3; dec_mode_i = 0;
        start_output_i = 1; tick(); start_output_i = 0;
        for (int k = 0; k < 2; k++) begin
            w = 0;
            while (!out_rdy_o && w < 20) begin tick(); w++; end
            out_ack_i = 1; tick(); out_ack_i = 0; tick();
        end
        tick();
        #2 resetn = 0;
        #1;
        checks++;
        if (snapshot() !== 21'd0) begin
            errors++; $display("FAIL reset_mid_shift: got %06h expected 000000", snapshot());
        end
        @(negedge clk); resetn = 1; tick();
        run_word(1'b1, 1'b1, 1'b0, 1'b0, 4'h0);
    endtask

    initial begin
        test_reset();
        test_oct_word();
        test_dec_word();
        test_random_words();
        test_input_codes();
        test_random_fifo();
        test_overflow();
        test_exclusion_stop();
        test_reset_mid_shift();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/io_stream_unit.md
IO_STREAM_UNIT -- requirements
Module: io_stream_unit

Interface
REQ-001 SHALL provide parameter CODE_W, default 5, meaning device code width in bits (minimum 5).
REQ-002 SHALL provide parameter FIFO_DEPTH, default 4, meaning input FIFO entries (power of two, at least 2).
REQ-003 SHALL provide parameter OCT_DIGITS, default 10, meaning digits emitted per word in octal mode.
REQ-004 SHALL provide parameter DEC_DIGITS, default 7, meaning digits emitted per word in decimal mode.
REQ-005 SHALL provide parameter END_CODE, default 5'b00111, meaning the input code that terminates input.
REQ-006 SHALL have port list (name direction width meaning): clk in 1 clock; resetn in 1 reset.
REQ-007 SHALL have port list: start_input_i / stop_input_i / start_output_i / stop_output_i in 1 pulses; dec_mode_i in 1 level (0 = oct, 1 = dec).
REQ-008 SHALL have port list: in_rdy_o out 1; in_val_i in 1; in_data_i in CODE_W (device input handshake).
REQ-009 SHALL have port list: code_valid_o out 1; code_data_o out CODE_W; code_pop_i in 1 (core consumer side); fifo_level_o out clog2(FIFO_DEPTH)+1; overflow_o out 1 sticky.
REQ-010 SHALL have port list: out_rdy_o out 1; out_ack_i in 1; out_data_o out CODE_W (device output handshake).
REQ-011 SHALL have port list: sign_i in 1; digit_i in 4; shift_req_o out 1 pulse; shift_done_i in 1 pulse; out_finish_o out 1 pulse.
REQ-012 SHALL have port list: input_active_o, output_active_o out 1 levels.
REQ-013 SHALL use one clock, clk; reset resetn is asynchronous and active-low.

Function
REQ-014 SHALL keep input_active and output_active mutually exclusive: a start is ignored while the other direction is active, and stop wins over start in the same cycle.
REQ-015 SHALL latch dec_mode_i when output starts and hold it for the whole word.
REQ-016 SHALL run the input FSM IDLE->RDY->VAL->RDY; in_rdy_o = (state==RDY) and FIFO not full.
REQ-017 SHALL push in_data_i into the FIFO on the cycle in RDY where in_rdy_o and in_val_i are both high, then wait in VAL for in_val_i low.
REQ-018 SHALL, on pushing END_CODE, complete the VAL phase and then clear input_active; the FIFO contents are kept.
REQ-019 SHALL make code_valid_o = FIFO not empty with code_data_o = head entry; code_pop_i while empty is ignored; simultaneous push and pop leave the level unchanged.
REQ-020 SHALL set overflow_o if in_val_i rises in RDY while the FIFO is full; the code is dropped and the FSM stays in RDY.
REQ-021 SHALL flush the FIFO and clear overflow_o on start_input_i accepted.
REQ-022 SHALL, on stop_input_i, drop in_rdy_o next cycle and return the FSM to IDLE, even mid-handshake.
REQ-023 SHALL run the output FSM IDLE->RDY->ACK->NEXT->(SHIFT->)RDY with index counter idx, where N = DEC_DIGITS or OCT_DIGITS.
REQ-024 SHALL drive out_data_o, right-aligned with zero upper bits, as: idx0 = {1111, sign_i}; idx 1..N = oct {10, digit_i[3:1]} or dec {1, digit_i[3:0]}; idx N+1 = 00110.
REQ-025 SHALL assert out_rdy_o in RDY and hold out_data_o stable from RDY entry until out_ack_i falls.
REQ-026 SHALL advance from ACK to NEXT when out_ack_i falls.
REQ-027 SHALL, in NEXT after a digit, pulse shift_req_o for one cycle and wait in SHIFT for shift_done_i; after the sign it goes directly to RDY.
REQ-028 SHALL, in NEXT after idx N+1, pulse out_finish_o, clear output_active, and reset idx to 0.
REQ-029 SHALL, on stop_output_i, abort to IDLE with idx 0 and no out_finish_o pulse.
REQ-030 SHALL accept shift_done_i arriving in the same cycle as shift_req_o.

Reset
REQ-031 SHALL clear every output to 0 on reset, including FIFO pointers, overflow, idx, both FSMs (IDLE) and the latched mode.

Structure
REQ-032 SHALL place FSM state encodings and the sign/finish code constants in shared package io_pkg.
REQ-033 SHALL implement the input buffer as a sub-module io_sync_fifo (parameters WIDTH, DEPTH; push, pop, level, full, empty).

Verification
REQ-034 SHALL cover: oct output, sign=1, digits 1..10 = 4'hE -> out_data 11111, then 10111 ×10, then 00110; 10 shift_req pulses; one out_finish.
REQ-035 SHALL cover: dec output, digit 4'h9 -> out_data 11001 ×7, then 00110 at idx 8.
REQ-036 SHALL cover: input codes 10011, 10101, 00111 with no pops -> fifo_level 3, input_active clears after END_CODE, heads popped in order.
REQ-037 SHALL cover: DEPTH=4 with no pops -> in_rdy_o low after 4 pushes; a forced 5th val rise sets overflow_o and the level stays 4.
REQ-038 SHALL cover: start_output_i while input_active -> ignored; stop_output_i during ACK -> out_rdy low, no out_finish.
REQ-039 SHALL cover: resetn asserted mid-SHIFT -> all outputs 0 immediately; the next start_output_i begins at idx0.
